rx_comma_aligner: RTL

- Receive-side word aligner for the 8b/10b serial link; the counterpart of the transmit encoder and PISO framing.
- Consumes the serial bit stream on recovered_clock and hunts for the K28.5 comma in either running disparity.
- Locks the 10-bit symbol boundary and emits aligned RxParallel_10 words with a one-cycle word_valid strobe for the decoder.
- Tracks lock and drops it after repeated misaligned commas.

---
 rtl/rx_comma_aligner.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rx_comma_aligner.sv
// Receive-side 8b/10b word aligner: hunts for K28.5 in the serial stream, locks the
// 10-bit symbol boundary and emits aligned words with a one-cycle word_valid strobe.
module rx_comma_aligner #(
  parameter logic [9:0]  COMMA_N      = 10'b0011111010,
  parameter logic [9:0]  COMMA_P      = 10'b1100000101,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 4
) (
  input  logic       recovered_clock,
  input  logic       Reset,
  input  logic       Serial,
  input  logic       align_en,
  output logic [9:0] RxParallel_10,
  output logic       word_valid,
  output logic       comma_det,
  output logic       locked
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BMAX = BW'(UNLOCK_COUNT);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]    state;
  logic [9:0]    sr;
  logic [3:0]    phase;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;
  logic          match;
  logic          boundary;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;

  always_comb begin
    match    = align_en && ((sr == COMMA_N) || (sr == COMMA_P));
    boundary = (phase == 4'd0);
    good_inc = (good_cnt == GMAX) ? good_cnt : good_cnt + GW'(1);
    bad_inc  = (bad_cnt == BMAX) ? bad_cnt : bad_cnt + BW'(1);
  end

  // A comma loads phase with 1 so the next boundary lands exactly 10 bits later.
  always_ff @(posedge recovered_clock or negedge Reset) begin
    if (!Reset) begin
      state         <= HUNT;
      sr            <= '0;
      phase         <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      RxParallel_10 <= '0;
      word_valid    <= 1'b0;
      comma_det     <= 1'b0;
      locked        <= 1'b0;
    end else begin
      sr         <= {sr[8:0], Serial};
      word_valid <= 1'b0;
      comma_det  <= 1'b0;
      if (state != HUNT)
        phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;

      case (state)
        HUNT: begin
          if (match) begin
            RxParallel_10 <= sr;
            word_valid    <= 1'b1;
            comma_det     <= 1'b1;
            phase         <= 4'd1;
            good_cnt      <= GW'(1);
            bad_cnt       <= '0;
            if (LOCK_COUNT <= 1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end

        SYNC: begin
          if (boundary) begin
            RxParallel_10 <= sr;
            word_valid    <= 1'b1;
            comma_det     <= match;
            if (match) begin
              good_cnt <= good_inc;
              if (good_inc == GMAX) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                bad_cnt <= '0;
              end
            end
          end else if (match) begin
            RxParallel_10 <= sr;
            word_valid    <= 1'b1;
            comma_det     <= 1'b1;
            phase         <= 4'd1;
            good_cnt      <= GW'(1);
          end
        end

        LOCKED: begin
          if (boundary) begin
            RxParallel_10 <= sr;
            word_valid    <= 1'b1;
            comma_det     <= match;
            if (match)
              bad_cnt <= '0;
          end else if (match) begin
            if (bad_inc == BMAX) begin
              state   <= HUNT;
              locked  <= 1'b0;
              bad_cnt <= '0;
            end else begin
              bad_cnt <= bad_inc;
            end
          end
        end

        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
